// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file and its
// pending-write scoreboard.
//   XLEN   : data word width
//   NREGS  : architectural register count (x0 hardwired to zero)
//   REG_AW : register address width
//   CNT_W  : per-register pending-write counter width
package rf_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREGS  = 32;
  localparam int unsigned REG_AW = $clog2(NREGS);
  localparam int unsigned CNT_W  = 2;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_cnt.sv
// sb_cnt: saturating up/down pending-write counter for one register.
// Optional feature macro: RF_WB_BYPASS_EN (busy drops in the writeback cycle
// that retires the last pending write).
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   inc_i          : an accepted issue targets this register
//   dec_i          : writeback writes this register this cycle (unqualified)
//   clr_i          : flush, count returns to zero next edge
//   busy_o         : a write to this register is still in flight
//   full_o         : counter saturated, no further writer may issue
//   underflow_o    : writeback arrived with no pending write
module sb_cnt
  import rf_pkg::*;
#(
  parameter int unsigned CNT_W = rf_pkg::CNT_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic busy_o,
  output logic full_o,
  output logic underflow_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             empty;
  logic             take;

  assign empty = (cnt_q == '0);
  assign full_o = (cnt_q == '1);
  // A writeback only retires a pending write when one exists.
  assign take = dec_i & ~empty;
  assign underflow_o = dec_i & empty;

`ifdef RF_WB_BYPASS_EN
  assign busy_o = ~empty & ~((cnt_q == CNT_W'(1)) & dec_i);
`else
  assign busy_o = ~empty;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !take && !full_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (take && !inc_i) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with per-register pending-write
// scoreboard. Decode reads operands and announces destinations; issue is
// stalled while a source has a write in flight or the destination counter
// is saturated. Writeback commits data and retires pending writes.
// Optional feature macro: RF_WB_BYPASS_EN (writeback data forwarded to reads
// and stall released in the writeback cycle).
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   rs1_addr_i/rs2_addr_i        : source addresses
//   rs1_data_o/rs2_data_o        : combinational operand data
//   issue_valid_i/issue_wren_i/issue_rd_i : presented instruction
//   issue_stall_o                : hold presented instruction in decode
//   wb_wren_i/wb_rd_i/wb_data_i  : writeback write port
//   flush_i                      : squash all in-flight writes
//   sb_underflow_o               : sticky writeback-without-pending error
module reg_file_sb #(
  parameter int unsigned XLEN  = rf_pkg::XLEN,
  parameter int unsigned NREGS = rf_pkg::NREGS,
  parameter int unsigned CNT_W = rf_pkg::CNT_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [$clog2(NREGS)-1:0] rs1_addr_i,
  input  logic [$clog2(NREGS)-1:0] rs2_addr_i,
  output logic [XLEN-1:0]          rs1_data_o,
  output logic [XLEN-1:0]          rs2_data_o,
  input  logic                     issue_valid_i,
  input  logic                     issue_wren_i,
  input  logic [$clog2(NREGS)-1:0] issue_rd_i,
  output logic                     issue_stall_o,
  input  logic                     wb_wren_i,
  input  logic [$clog2(NREGS)-1:0] wb_rd_i,
  input  logic [XLEN-1:0]          wb_data_i,
  input  logic                     flush_i,
  output logic                     sb_underflow_o
);

  import rf_pkg::*;

  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  mem_q [NREGS];
  logic [XLEN-1:0]  mem_d [NREGS];
  logic             uf_q, uf_d;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] full;
  logic [NREGS-1:0] uf;
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] wb_hit;
  logic             issue_accept;
  logic             wb_write;

  assign wb_write = wb_wren_i && (wb_rd_i != '0);

  // x0 has no counter: never busy, never full, never underflows.
  assign busy[0]   = 1'b0;
  assign full[0]   = 1'b0;
  assign uf[0]     = 1'b0;
  assign inc[0]    = 1'b0;
  assign wb_hit[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_cnt
    assign wb_hit[r] = wb_wren_i && (wb_rd_i == AW'(r));
    assign inc[r]    = issue_accept && issue_wren_i && (issue_rd_i == AW'(r));

    sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .inc_i       (inc[r]),
      .dec_i       (wb_hit[r]),
      .clr_i       (flush_i),
      .busy_o      (busy[r]),
      .full_o      (full[r]),
      .underflow_o (uf[r])
    );
  end

  always_comb begin
    issue_stall_o = issue_valid_i &&
                    (busy[rs1_addr_i] || busy[rs2_addr_i] ||
                     (issue_wren_i && (issue_rd_i != '0) && full[issue_rd_i]));
  end

  // Flush squashes the same-cycle issue so it is never counted.
  assign issue_accept = issue_valid_i && !issue_stall_o && !flush_i;

  always_comb begin
    rs1_data_o = mem_q[rs1_addr_i];
`ifdef RF_WB_BYPASS_EN
    if (wb_wren_i && (wb_rd_i == rs1_addr_i)) rs1_data_o = wb_data_i;
`endif
    if (rs1_addr_i == '0) rs1_data_o = '0;
  end

  always_comb begin
    rs2_data_o = mem_q[rs2_addr_i];
`ifdef RF_WB_BYPASS_EN
    if (wb_wren_i && (wb_rd_i == rs2_addr_i)) rs2_data_o = wb_data_i;
`endif
    if (rs2_addr_i == '0) rs2_data_o = '0;
  end

  // Writeback is already flush-qualified, so it lands even during flush.
  always_comb begin
    mem_d = mem_q;
    if (wb_write) mem_d[wb_rd_i] = wb_data_i;
  end

  always_comb begin
    uf_d = uf_q | (|uf);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
      uf_q  <= 1'b0;
    end else begin
      mem_q <= mem_d;
      uf_q  <= uf_d;
    end
  end

  assign sb_underflow_o = uf_q;

endmodule
